// File: rtl/fifo_rd_ctrl.sv
// Read-side FIFO controller: read pointer, RAM read port, registered output with valid/ready,
// empty/almost_empty/level from the synchronised Gray write pointer. Optional checker: FIFO_RD_PTR_CHK_EN.
module fifo_rd_ctrl #(
    parameter int a_width   = 4,
    parameter int d_width   = 16,
    parameter int ae_thresh = 2
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic [a_width:0]   wr_ptr_gray_sync,
    output logic               rd_en,
    output logic [a_width-1:0] rd_addr,
    input  logic [d_width-1:0] rd_data_mem,
    output logic [a_width:0]   rd_ptr_gray,
    output logic [d_width-1:0] out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               empty,
    output logic               almost_empty,
    output logic [a_width:0]   rd_level,
    output logic               ptr_err
);

    localparam logic [a_width:0] c_depth     = (a_width+1)'(2**a_width);
    localparam logic [a_width:0] c_ae_thresh = (a_width+1)'(ae_thresh);

    function automatic logic [a_width:0] gray2bin(input logic [a_width:0] g);
        logic [a_width:0] b;
        b[a_width] = g[a_width];
        for (int i = a_width - 1; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic logic [a_width:0] bin2gray(input logic [a_width:0] b);
        return (b >> 1) ^ b;
    endfunction

    logic [a_width:0]   r_rd_bin;
    logic [a_width:0]   r_rd_ptr_gray;
    logic [d_width-1:0] r_out_data;
    logic               r_out_valid;
    logic               r_ptr_err;

    logic [a_width:0]   w_wr_bin;
    logic [a_width:0]   w_rd_bin_nxt;
    logic [a_width:0]   w_level;
    logic               w_empty;
    logic               w_load;

    assign w_wr_bin     = gray2bin(wr_ptr_gray_sync);
    assign w_rd_bin_nxt = r_rd_bin + (a_width+1)'(1);
    // Unsigned wrap-around subtraction; the extra MSB keeps full (depth) distinct from empty (0).
    assign w_level      = w_wr_bin - r_rd_bin;
    assign w_empty      = (r_rd_ptr_gray == wr_ptr_gray_sync);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_load = 1'b0;
        if (!w_empty && (!r_out_valid || out_ready) && !r_ptr_err) begin
            w_load = 1'b1;
        end
    end

    // NOTE: state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_rd_bin      <= '0;
            r_rd_ptr_gray <= '0;
            r_out_data    <= '0;
            r_out_valid   <= 1'b0;
        end else if (w_load) begin
            r_out_data    <= rd_data_mem;
            r_out_valid   <= 1'b1;
            r_rd_bin      <= w_rd_bin_nxt;
            r_rd_ptr_gray <= bin2gray(w_rd_bin_nxt);
        end else if (r_out_valid && out_ready) begin
            r_out_valid   <= 1'b0;
        end
    end

`ifdef FIFO_RD_PTR_CHK_EN
    // A level beyond the RAM depth can only come from a corrupted synchronised pointer.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_ptr_err <= 1'b0;
        end else if (w_level > c_depth) begin
            r_ptr_err <= 1'b1;
        end
    end
`else
    assign r_ptr_err = 1'b0;
`endif

    assign rd_en        = w_load;
    assign rd_addr      = r_rd_bin[a_width-1:0];
    assign rd_ptr_gray  = r_rd_ptr_gray;
    assign out_data     = r_out_data;
    assign out_valid    = r_out_valid;
    assign empty        = w_empty;
    assign almost_empty = (w_level <= c_ae_thresh);
    assign rd_level     = w_level;
    assign ptr_err      = r_ptr_err;

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Self-checking bench for fifo_rd_ctrl: RAM model, scoreboard queue, negedge output monitor.
module tb_fifo_rd_ctrl;

    localparam int AW = 4;
    localparam int DW = 16;

    logic          Clk = 1'b0;
    logic          Rst;
    logic [AW:0]   wr_ptr_gray_sync;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data_mem;
    logic [AW:0]   rd_ptr_gray;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          empty;
    logic          almost_empty;
    logic [AW:0]   rd_level;
    logic          ptr_err;

    fifo_rd_ctrl #(.a_width(AW), .d_width(DW), .ae_thresh(2)) dut (
        .Clk              (Clk),
        .Rst              (Rst),
        .wr_ptr_gray_sync (wr_ptr_gray_sync),
        .rd_en            (rd_en),
        .rd_addr          (rd_addr),
        .rd_data_mem      (rd_data_mem),
        .rd_ptr_gray      (rd_ptr_gray),
        .out_data         (out_data),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .empty            (empty),
        .almost_empty     (almost_empty),
        .rd_level         (rd_level),
        .ptr_err          (ptr_err)
    );

    always #5 Clk = ~Clk;

    logic [DW-1:0] ram [2**AW];
    assign rd_data_mem = ram[rd_addr];

    int            n_checks = 0;
    int            n_pass   = 0;
    logic [DW-1:0] sb [$];
    logic [AW:0]   wr_bin;
    int            n_push = 0;
    int            n_pop  = 0;
    bit            mon_en = 1'b0;
    int            addr_wraps = 0;
    int            gray_wraps = 0;

    function automatic logic [AW:0] b2g(input logic [AW:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [AW:0] g2b(input logic [AW:0] g);
        logic [AW:0] b;
        b = '0;
        for (int i = AW; i >= 0; i--) begin
            b[i] = g[i] ^ ((i == AW) ? 1'b0 : b[i+1]);
        end
        return b;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: observed %0h required %0h (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic push_word(input logic [DW-1:0] d);
        ram[wr_bin[AW-1:0]] = d;
        wr_bin = wr_bin + 1'b1;
        wr_ptr_gray_sync = b2g(wr_bin);
        sb.push_back(d);
        n_push++;
    endtask

    task automatic do_reset();
        Rst = 1'b1;
        out_ready = 1'b0;
        wr_bin = '0;
        wr_ptr_gray_sync = '0;
        sb.delete();
        repeat (2) @(posedge Clk);
        #1 Rst = 1'b0;
    endtask

    task automatic wait_drained(input int budget);
        int n = 0;
        out_ready = 1'b1;
        while (!(empty && !out_valid) && n < budget) begin
            @(posedge Clk); #1;
            n++;
        end
        check("drain_done", {31'b0, empty && !out_valid}, 1);
        check("idle_rd_en", {31'b0, rd_en}, 0);
        check("sb_drained", sb.size(), 0);
    endtask

    // Output monitor: words are consumed at the posedge following a negedge that sees valid && ready.
    logic [AW:0]   m_prev_bin = '0;
    logic [AW-1:0] m_prev_addr = '0;
    logic [AW:0]   m_prev_gray = '0;
    bit            m_held = 1'b0;
    logic [DW-1:0] m_held_data = '0;
    always @(negedge Clk) begin
        logic [AW:0] cur_bin;
        logic [AW:0] step;
        if (mon_en && !Rst) begin
            cur_bin = g2b(rd_ptr_gray);
            step = cur_bin - m_prev_bin;
            check("rd_ptr_step", {31'b0, step <= 1}, 1);
            check("rd_addr_ptr", {28'b0, rd_addr}, {28'b0, cur_bin[AW-1:0]});
            if (m_prev_addr == 4'd15 && rd_addr == 4'd0) addr_wraps++;
            if (m_prev_gray == b2g(5'd31) && rd_ptr_gray == 5'd0) gray_wraps++;
            if (m_held) begin
                check("hold_valid", {31'b0, out_valid}, 1);
                check("hold_data", {16'b0, out_data}, {16'b0, m_held_data});
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("sb_underflow", 1, 0);
                end else begin
                    check("out_data", {16'b0, out_data}, {16'b0, sb.pop_front()});
                end
                n_pop++;
            end
            m_held      = out_valid && !out_ready;
            m_held_data = out_data;
            m_prev_bin  = cur_bin;
            m_prev_addr = rd_addr;
            m_prev_gray = rd_ptr_gray;
        end else begin
            m_held      = 1'b0;
            m_prev_bin  = '0;
            m_prev_addr = '0;
            m_prev_gray = '0;
        end
    end

    initial begin
        int start_pop;
        int pushed;
        int cyc;
        for (int i = 0; i < 2**AW; i++) ram[i] = '0;

        // 1: reset state
        do_reset();
        check("rst_valid", {31'b0, out_valid}, 0);
        check("rst_empty", {31'b0, empty}, 1);
        check("rst_aempty", {31'b0, almost_empty}, 1);
        check("rst_level", {27'b0, rd_level}, 0);
        check("rst_gray", {27'b0, rd_ptr_gray}, 0);
        check("rst_rd_en", {31'b0, rd_en}, 0);
        check("rst_ptr_err", {31'b0, ptr_err}, 0);
        mon_en = 1'b1;

        // 2: single word, held under backpressure, then consumed
        push_word(16'hA5A5);
        #1;
        check("t2_rd_en", {31'b0, rd_en}, 1);
        check("t2_addr", {28'b0, rd_addr}, 0);
        check("t2_level", {27'b0, rd_level}, 1);
        check("t2_empty_pre", {31'b0, empty}, 0);
        @(posedge Clk); #1;
        check("t2_valid", {31'b0, out_valid}, 1);
        check("t2_data", {16'b0, out_data}, 32'hA5A5);
        check("t2_gray", {27'b0, rd_ptr_gray}, 1);
        check("t2_empty", {31'b0, empty}, 1);
        repeat (3) @(posedge Clk);
        #1 check("t2_held", {16'b0, out_data}, 32'hA5A5);
        out_ready = 1'b1;
        @(posedge Clk); #1;
        check("t2_drop", {31'b0, out_valid}, 0);
        wait_drained(10);

        // 3: full preload, stream at one word per cycle
        do_reset();
        for (int i = 0; i < 16; i++) push_word(DW'($urandom_range(0, 65535)));
        #1;
        check("t3_wr_gray", {27'b0, wr_ptr_gray_sync}, 32'h18);
        for (int k = 0; k <= 16; k++) begin
            check("t3_level", {27'b0, rd_level}, 32'(16 - k));
            check("t3_aempty", {31'b0, almost_empty}, {31'b0, (16 - k) <= 2});
            check("t3_empty", {31'b0, empty}, {31'b0, k == 16});
            if (k > 0) check("t3_valid", {31'b0, out_valid}, 1);
            out_ready = 1'b1;
            @(posedge Clk); #1;
        end
        check("t3_last_drop", {31'b0, out_valid}, 0);
        check("t3_gray_end", {27'b0, rd_ptr_gray}, 32'h18);
        wait_drained(10);

        // 4: backpressure pattern on four words
        start_pop = n_pop;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) push_word(16'h1000 + 16'(i));
        begin
            logic [4:0] pat;
            pat = 5'b11001;
            for (int i = 4; i >= 0; i--) begin
                out_ready = pat[i];
                @(posedge Clk); #1;
            end
        end
        wait_drained(20);
        check("t4_pops", n_pop - start_pop, 4);

        // 5: 40 words with random flow control, crossing both address and pointer wrap
        addr_wraps = 0;
        gray_wraps = 0;
        start_pop = n_pop;
        pushed = 0;
        cyc = 0;
        while (n_pop < start_pop + 40 && cyc < 2000) begin
            if (pushed < 40 && (n_push - n_pop) < 16 && $urandom_range(0, 3) != 0) begin
                push_word(DW'($urandom_range(0, 65535)));
                pushed++;
            end
            out_ready = ($urandom_range(0, 3) != 0);
            @(posedge Clk); #1;
            cyc++;
        end
        check("t5_done", {31'b0, n_pop >= start_pop + 40}, 1);
        wait_drained(40);
        check("t5_addr_wraps", addr_wraps, 2);
        check("t5_gray_wraps", gray_wraps, 1);
        check("t5_gray_end", {27'b0, rd_ptr_gray}, {27'b0, b2g(5'd28)});

        // 6: corrupted synchronised pointer (level 20 > depth)
        mon_en = 1'b0;
        do_reset();
        wr_ptr_gray_sync = b2g(5'd20);
        #1 check("t6_level", {27'b0, rd_level}, 20);
        @(posedge Clk); #1;
`ifdef FIFO_RD_PTR_CHK_EN
        check("t6_err_set", {31'b0, ptr_err}, 1);
        for (int i = 0; i < 3; i++) begin
            check("t6_rd_en_off", {31'b0, rd_en}, 0);
            @(posedge Clk); #1;
        end
        out_ready = 1'b1;
        @(posedge Clk); #1;
        check("t6_drain", {31'b0, out_valid}, 0);
        check("t6_still_off", {31'b0, rd_en}, 0);
        check("t6_sticky", {31'b0, ptr_err}, 1);
`else
        for (int i = 0; i < 3; i++) begin
            check("t6_no_err", {31'b0, ptr_err}, 0);
            @(posedge Clk); #1;
        end
`endif
        do_reset();
        check("t6_err_clr", {31'b0, ptr_err}, 0);
        check("t6_rst_valid", {31'b0, out_valid}, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
